// File: rtl/cheri_tsmap_arbiter.sv
// rtl/cheri_tsmap_arbiter.sv - TS map SRAM read-port arbiter (core lookup vs background sweep)
// Grants one read per cycle with zero-cycle arbitration. Core wins contention
// until it has won MaxCoreStreak contended grants in a row, then the sweep
// engine is forced one grant. Read data returns one cycle after the grant and
// is steered only to the owner of that grant.
module cheri_tsmap_arbiter #(
  parameter int AddrW         = 16,
  parameter int DataW         = 32,
  parameter int MaxCoreStreak = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             core_req_i,
  input  logic [AddrW-1:0] core_addr_i,
  output logic             core_gnt_o,
  output logic             core_rvalid_o,
  output logic [DataW-1:0] core_rdata_o,
  input  logic             bg_req_i,
  input  logic [AddrW-1:0] bg_addr_i,
  output logic             bg_gnt_o,
  output logic             bg_rvalid_o,
  output logic [DataW-1:0] bg_rdata_o,
  output logic             tsmap_cs_o,
  output logic [AddrW-1:0] tsmap_addr_o,
  input  logic [DataW-1:0] tsmap_rdata_i,
  output logic [7:0]       bg_starve_cnt_o
);

  localparam logic [3:0] StreakMax = 4'(MaxCoreStreak);

  logic [3:0] streak_q, streak_d;
  logic [7:0] starve_q, starve_d;
  logic       rsp_vld_q, rsp_own_q;
  logic       streak_hit, core_gnt, bg_gnt, forced_bg;

  // Grant decision: bg wins if alone or if the core streak has hit its limit.
  // Grants are suppressed while reset is asserted.
  always_comb begin
    streak_hit = (streak_q == StreakMax);
    bg_gnt     = ~rst_i & bg_req_i & (~core_req_i | streak_hit);
    core_gnt   = ~rst_i & core_req_i & ~bg_gnt;
    forced_bg  = bg_gnt & core_req_i;
  end

  // SRAM port drive: address of the granted requester, zero when idle.
  always_comb begin
    tsmap_cs_o = core_gnt | bg_gnt;
    if (core_gnt) begin
      tsmap_addr_o = core_addr_i;
    end else if (bg_gnt) begin
      tsmap_addr_o = bg_addr_i;
    end else begin
      tsmap_addr_o = '0;
    end
  end

  // Next-state for the contended-core streak and the forced-grant counter.
  always_comb begin
    streak_d = 4'd0;
    if (core_gnt && bg_req_i) begin
      streak_d = streak_hit ? streak_q : streak_q + 4'd1;
    end
    starve_d = starve_q;
    if (forced_bg && (starve_q != 8'hFF)) begin
      starve_d = starve_q + 8'd1;
    end
  end

  // State registers; reset drops any in-flight response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      streak_q  <= 4'd0;
      starve_q  <= 8'd0;
      rsp_vld_q <= 1'b0;
      rsp_own_q <= 1'b0;
    end else begin
      streak_q  <= streak_d;
      starve_q  <= starve_d;
      rsp_vld_q <= tsmap_cs_o;
      rsp_own_q <= bg_gnt;
    end
  end

  // Response steering: data only reaches the owner of last cycle's grant.
  always_comb begin
    core_gnt_o      = core_gnt;
    bg_gnt_o        = bg_gnt;
    core_rvalid_o   = rsp_vld_q & ~rsp_own_q;
    bg_rvalid_o     = rsp_vld_q & rsp_own_q;
    core_rdata_o    = core_rvalid_o ? tsmap_rdata_i : '0;
    bg_rdata_o      = bg_rvalid_o ? tsmap_rdata_i : '0;
    bg_starve_cnt_o = starve_q;
  end

endmodule

// File: tb/tb_cheri_tsmap_arbiter.sv
// tb/tb_cheri_tsmap_arbiter.sv - self-checking bench for cheri_tsmap_arbiter
module tb_cheri_tsmap_arbiter;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        core_req_i = 1'b0;
  logic [15:0] core_addr_i = '0;
  logic        core_gnt_o, core_rvalid_o;
  logic [31:0] core_rdata_o;
  logic        bg_req_i = 1'b0;
  logic [15:0] bg_addr_i = '0;
  logic        bg_gnt_o, bg_rvalid_o;
  logic [31:0] bg_rdata_o;
  logic        tsmap_cs_o;
  logic [15:0] tsmap_addr_o;
  logic [31:0] tsmap_rdata_i = '0;
  logic [7:0]  bg_starve_cnt_o;

  int errors = 0;
  int checks = 0;

  // reference model state
  int          m_streak, m_starve;
  bit          m_vld, m_own;
  logic [15:0] m_raddr;
  logic        e_gc, e_gb;
  logic [15:0] e_addr;
  logic [92:0] e_vec;

  always #5 clk = ~clk;

  cheri_tsmap_arbiter #(.AddrW(16), .DataW(32), .MaxCoreStreak(MAX)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .core_req_i(core_req_i), .core_addr_i(core_addr_i), .core_gnt_o(core_gnt_o),
    .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
    .bg_req_i(bg_req_i), .bg_addr_i(bg_addr_i), .bg_gnt_o(bg_gnt_o),
    .bg_rvalid_o(bg_rvalid_o), .bg_rdata_o(bg_rdata_o),
    .tsmap_cs_o(tsmap_cs_o), .tsmap_addr_o(tsmap_addr_o), .tsmap_rdata_i(tsmap_rdata_i),
    .bg_starve_cnt_o(bg_starve_cnt_o)
  );

  function automatic logic [31:0] sram_f(input logic [15:0] a);
    return {a ^ 16'hA5C3, ~a};
  endfunction

  // SRAM: 1-cycle read latency; garbage on the bus when not selected
  always @(posedge clk) tsmap_rdata_i <= tsmap_cs_o ? sram_f(tsmap_addr_o) : $urandom;

  function automatic logic [92:0] observed();
    return {core_gnt_o, bg_gnt_o, tsmap_cs_o, tsmap_addr_o, core_rvalid_o, core_rdata_o,
            bg_rvalid_o, bg_rdata_o, bg_starve_cnt_o};
  endfunction

  task automatic model_reset();
    m_streak = 0; m_starve = 0; m_vld = 0; m_own = 0; m_raddr = '0;
  endtask

  // expected outputs for the current inputs, from the arbitration rules
  task automatic model_comb();
    logic [31:0] cd, bd;
    if (rst_i) begin
      e_gc = 0; e_gb = 0; e_addr = '0; e_vec = '0;
    end else begin
      e_gb   = bg_req_i && (!core_req_i || m_streak == MAX);
      e_gc   = core_req_i && !e_gb;
      e_addr = e_gc ? core_addr_i : (e_gb ? bg_addr_i : 16'h0);
      cd = (m_vld && !m_own) ? sram_f(m_raddr) : 32'h0;
      bd = (m_vld && m_own) ? sram_f(m_raddr) : 32'h0;
      e_vec = {e_gc, e_gb, e_gc | e_gb, e_addr, m_vld && !m_own, cd, m_vld && m_own, bd,
               8'(m_starve)};
    end
  endtask

  task automatic model_step();
    if (rst_i) return;
    if (e_gb && core_req_i && m_streak == MAX && m_starve < 255) m_starve++;
    m_streak = (bg_req_i && e_gc) ? ((m_streak < MAX) ? m_streak + 1 : MAX) : 0;
    m_vld = e_gc | e_gb; m_own = e_gb; m_raddr = e_addr;
  endtask

  task automatic settle();
    model_comb();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    core_req_i = 0; bg_req_i = 0;
    rst_i = 1; model_reset();
    @(posedge clk); #1;
    rst_i = 0;
  endtask

  task automatic test_reset();
    model_reset();
    core_req_i = 1; bg_req_i = 1; core_addr_i = 16'h1234; bg_addr_i = 16'h4321;
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++;
      if (observed() !== e_vec) begin
        errors++; $display("FAIL reset_outputs obs=%h exp=%h", observed(), e_vec);
      end
      advance();
    end
    core_req_i = 0; bg_req_i = 0;
    rst_i = 0;
  endtask

  task automatic test_core_only();
    int gnts = 0, crv = 0, brv = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      core_req_i = (i < 6);
      core_addr_i = (i < 6) ? 16'(16'h10 + i) : 16'h0;
      settle();
      checks++;
      if (observed() !== e_vec) begin
        errors++; $display("FAIL core_only cyc=%0d obs=%h exp=%h", i, observed(), e_vec);
      end
      gnts += core_gnt_o; crv += core_rvalid_o; brv += bg_rvalid_o;
      advance();
    end
    checks++;
    if (gnts !== 6 || crv !== 6 || brv !== 0) begin
      errors++; $display("FAIL core_only_counts gnt=%0d crv=%0d brv=%0d exp 6/6/0", gnts, crv, brv);
    end
  endtask

  task automatic test_contention();
    string pat = "";
    do_reset();
    core_req_i = 1; bg_req_i = 1; core_addr_i = 16'h0100; bg_addr_i = 16'h0200;
    for (int i = 0; i < 11; i++) begin
      settle();
      checks++;
      if (observed() !== e_vec) begin
        errors++; $display("FAIL contention cyc=%0d obs=%h exp=%h", i, observed(), e_vec);
      end
      if (i == 5) begin
        checks++;
        if (bg_starve_cnt_o !== 8'd1) begin
          errors++; $display("FAIL starve_after_b1 obs=%0d exp=1", bg_starve_cnt_o);
        end
      end
      if (i == 10) begin
        checks++;
        if (bg_starve_cnt_o !== 8'd2) begin
          errors++; $display("FAIL starve_after_b2 obs=%0d exp=2", bg_starve_cnt_o);
        end
      end
      if (i < 10) pat = {pat, core_gnt_o ? "C" : (bg_gnt_o ? "B" : "-")};
      advance();
    end
    checks++;
    if (pat != "CCCCBCCCCB") begin
      errors++; $display("FAIL contention_pattern obs=%s exp=CCCCBCCCCB", pat);
    end
    core_req_i = 0; bg_req_i = 0;
  endtask

  task automatic test_bg_only();
    do_reset();
    bg_req_i = 1; bg_addr_i = 16'h0ABC;
    settle();
    checks++;
    if (observed() !== e_vec || bg_gnt_o !== 1'b1 || tsmap_addr_o !== 16'h0ABC) begin
      errors++; $display("FAIL bg_only_grant obs=%h exp=%h", observed(), e_vec);
    end
    advance();
    bg_req_i = 0;
    settle();
    checks++;
    if (observed() !== e_vec || bg_rvalid_o !== 1'b1 || core_rdata_o !== 32'h0
        || bg_rdata_o !== sram_f(16'h0ABC)) begin
      errors++; $display("FAIL bg_only_rsp obs=%h exp=%h", observed(), e_vec);
    end
    advance();
  endtask

  task automatic test_streak_clear();
    string pat = "";
    do_reset();
    core_req_i = 1; core_addr_i = 16'h0300; bg_addr_i = 16'h0400;
    for (int i = 0; i < 10; i++) begin
      bg_req_i = (i != 3);
      settle();
      checks++;
      if (observed() !== e_vec) begin
        errors++; $display("FAIL streak_clear cyc=%0d obs=%h exp=%h", i, observed(), e_vec);
      end
      pat = {pat, core_gnt_o ? "C" : (bg_gnt_o ? "B" : "-")};
      advance();
    end
    checks++;
    if (pat != "CCCCCCCCBC") begin
      errors++; $display("FAIL streak_clear_pattern obs=%s exp=CCCCCCCCBC", pat);
    end
    core_req_i = 0; bg_req_i = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    core_req_i = 1; core_addr_i = 16'h0033;
    settle();
    checks++;
    if (observed() !== e_vec) begin
      errors++; $display("FAIL rstmid_grant obs=%h exp=%h", observed(), e_vec);
    end
    advance();
    rst_i = 1; model_reset(); bg_req_i = 1; bg_addr_i = 16'h0044;
    settle();
    checks++;
    if (observed() !== e_vec || core_rvalid_o !== 1'b0) begin
      errors++; $display("FAIL rstmid_in_reset obs=%h exp=%h", observed(), e_vec);
    end
    advance();
    rst_i = 0;
    settle();
    checks++;
    if (observed() !== e_vec || core_gnt_o !== 1'b1) begin
      errors++; $display("FAIL rstmid_release obs=%h exp=%h", observed(), e_vec);
    end
    advance();
    core_req_i = 0; bg_req_i = 0;
    settle();
    checks++;
    if (observed() !== e_vec) begin
      errors++; $display("FAIL rstmid_after obs=%h exp=%h", observed(), e_vec);
    end
    advance();
  endtask

  task automatic test_idle();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if (observed() !== e_vec || tsmap_cs_o !== 1'b0 || tsmap_addr_o !== 16'h0
          || dut.streak_q !== 4'd0) begin
        errors++; $display("FAIL idle cyc=%0d obs=%h exp=%h streak=%0d", i, observed(), e_vec,
                           dut.streak_q);
      end
      advance();
    end
  endtask

  task automatic test_random();
    do_reset();
    e_gc = 0; e_gb = 0;
    for (int i = 0; i < 400; i++) begin
      if (!core_req_i || e_gc) begin
        core_req_i = ($urandom_range(0, 3) != 0); core_addr_i = 16'($urandom);
      end
      if (!bg_req_i || e_gb) begin
        bg_req_i = ($urandom_range(0, 3) != 0); bg_addr_i = 16'($urandom);
      end
      settle();
      checks++;
      if (observed() !== e_vec) begin
        errors++; $display("FAIL random cyc=%0d obs=%h exp=%h", i, observed(), e_vec);
      end
      advance();
    end
    core_req_i = 0; bg_req_i = 0;
  endtask

  initial begin
    test_reset();
    test_core_only();
    test_contention();
    test_bg_only();
    test_streak_clear();
    test_reset_mid();
    test_idle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
